// File: rtl/decoder_nto2n_seq_if.sv
// Bus bundle for decoder_nto2n_seq: control, address and dwell in; decode and status out.
interface decoder_nto2n_seq_if #(
    parameter int N       = 3,
    parameter int DWELL_W = 4
);
    logic                 EN;
    logic                 MODE;
    logic                 START;
    logic [N-1:0]         A;
    logic [DWELL_W-1:0]   DWELL;
    logic [(2**N)-1:0]    D;
    logic                 BUSY;
    logic                 DONE;

    modport master (
        output EN, MODE, START, A, DWELL,
        input  D, BUSY, DONE
    );

    modport slave (
        input  EN, MODE, START, A, DWELL,
        output D, BUSY, DONE
    );
endinterface

// File: rtl/decoder_nto2n_seq.sv
// N-to-2^N decoder with a direct mode and a timed scan mode.
//
// state  | meaning
// IDLE   | outputs inactive, waiting for a direct request or a scan start
// DIRECT | D follows one-hot of A with one cycle of latency
// SCAN   | walking 2^N indices from the captured start, DWELL+1 cycles each
module decoder_nto2n_seq #(
    parameter int N       = 3,
    parameter int DWELL_W = 4
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    decoder_nto2n_seq_if.slave   bus
);
    localparam int W = 2**N;
    localparam logic [N:0] LAST_STEP = (N+1)'(W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [N-1:0]         idx_q, idx_d;
    logic [DWELL_W-1:0]   dwell_cnt_q, dwell_cnt_d;
    logic [DWELL_W-1:0]   dwell_rld_q, dwell_rld_d;
    logic [N:0]           step_q, step_d;
    logic [W-1:0]         d_q, d_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    function automatic logic [W-1:0] onehot(input logic [N-1:0] i);
        return W'(1) << i;
    endfunction

    // State, counters and registered outputs; reset is synchronous and dominant.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            dwell_cnt_q <= '0;
            dwell_rld_q <= '0;
            step_q      <= '0;
            d_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            dwell_cnt_q <= dwell_cnt_d;
            dwell_rld_q <= dwell_rld_d;
            step_q      <= step_d;
            d_q         <= d_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next-state and next-output decision; EN beats MODE, MODE beats scan progress.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        dwell_cnt_d = dwell_cnt_q;
        dwell_rld_d = dwell_rld_q;
        step_d      = step_q;
        d_d         = '0;
        busy_d      = 1'b0;
        done_d      = 1'b0;

        if (!bus.EN) begin
            state_d = IDLE;
        end else if (!bus.MODE) begin
            state_d = DIRECT;
            d_d     = onehot(bus.A);
        end else if (state_q == SCAN) begin
            if (dwell_cnt_q == '0) begin
                if (step_q == LAST_STEP) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    idx_d       = idx_q + N'(1);
                    step_d      = step_q + (N+1)'(1);
                    dwell_cnt_d = dwell_rld_q;
                    d_d         = onehot(idx_d);
                    busy_d      = 1'b1;
                end
            end else begin
                dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
                d_d         = onehot(idx_q);
                busy_d      = 1'b1;
            end
        end else if (bus.START) begin
            state_d     = SCAN;
            idx_d       = bus.A;
            dwell_cnt_d = bus.DWELL;
            dwell_rld_d = bus.DWELL;
            step_d      = '0;
            d_d         = onehot(bus.A);
            busy_d      = 1'b1;
        end else begin
            state_d = IDLE;
        end
    end

    assign bus.D    = d_q;
    assign bus.BUSY = busy_q;
    assign bus.DONE = done_q;
endmodule

// File: tb/tb_decoder_nto2n_seq.sv
// Self-checking bench for decoder_nto2n_seq with N=3, DWELL_W=4.
module tb_decoder_nto2n_seq;
    logic clk;
    logic rst_n;

    decoder_nto2n_seq_if #(.N(3), .DWELL_W(4)) bus ();

    decoder_nto2n_seq #(.N(3), .DWELL_W(4)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a scan is described by its start index, dwell and elapsed cycles.
    logic [7:0] m_d;
    logic       m_busy;
    logic       m_done;
    bit         m_scan;
    int         m_a0;
    int         m_dw;
    int         m_t;

    typedef struct {
        logic       rst_n;
        logic       en;
        logic       mode;
        logic       start;
        logic [2:0] a;
        logic [3:0] dwell;
        logic [7:0] exp_d;
        logic       exp_busy;
        logic       exp_done;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        if (!rst_n || !bus.EN) begin
            m_scan = 0; m_d = 8'h00; m_busy = 0; m_done = 0;
        end else if (!bus.MODE) begin
            m_scan = 0; m_d = 8'h01 << bus.A; m_busy = 0; m_done = 0;
        end else if (m_scan) begin
            m_t++;
            if (m_t == 8 * (m_dw + 1)) begin
                m_scan = 0; m_d = 8'h00; m_busy = 0; m_done = 1;
            end else begin
                m_d = 8'h01 << ((m_a0 + m_t / (m_dw + 1)) % 8);
                m_busy = 1; m_done = 0;
            end
        end else if (bus.START) begin
            m_scan = 1; m_a0 = int'(bus.A); m_dw = int'(bus.DWELL); m_t = 0;
            m_d = 8'h01 << bus.A; m_busy = 1; m_done = 0;
        end else begin
            m_d = 8'h00; m_busy = 0; m_done = 0;
        end
    endtask

    // One clock edge: advance the model with the inputs seen at the edge, then compare.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        chk("model_d",    bus.D,           m_d);
        chk("model_busy", {7'd0, bus.BUSY}, {7'd0, m_busy});
        chk("model_done", {7'd0, bus.DONE}, {7'd0, m_done});
    endtask

    task automatic set_in(input logic r, input logic e, input logic m, input logic s,
                          input logic [2:0] a, input logic [3:0] dw);
        rst_n     = r;
        bus.EN    = e;
        bus.MODE  = m;
        bus.START = s;
        bus.A     = a;
        bus.DWELL = dw;
    endtask

    task automatic start_scan(input logic [2:0] a, input logic [3:0] dw);
        set_in(1, 1, 1, 1, a, dw);
        cycle();
        bus.START = 0;
    endtask

    initial begin
        logic [7:0] oh;
        logic [7:0] exp29 [8];
        int         k;
        bit         seen_done;

        m_d = 0; m_busy = 0; m_done = 0; m_scan = 0; m_a0 = 0; m_dw = 0; m_t = 0;
        set_in(0, 0, 0, 0, 3'd0, 4'd0);

        // Single-edge vectors.
        vecs.push_back('{0, 0, 0, 0, 3'd0, 4'd0, 8'h00, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 3'd2, 4'd0, 8'h00, 0, 0});
        oh = 8'h01;
        for (int i = 0; i < 8; i++) begin
            vecs.push_back('{1, 1, 0, 0, 3'(i), 4'd0, oh, 0, 0});
            oh = {oh[6:0], 1'b0};
        end
        vecs.push_back('{1, 0, 0, 0, 3'd4, 4'd0, 8'h00, 0, 0});
        vecs.push_back('{1, 1, 1, 0, 3'd5, 4'd0, 8'h00, 0, 0});
        vecs.push_back('{1, 1, 0, 0, 3'd7, 4'd0, 8'h80, 0, 0});
        vecs.push_back('{1, 1, 1, 1, 3'd6, 4'd0, 8'h40, 1, 0});
        vecs.push_back('{1, 1, 0, 0, 3'd3, 4'd0, 8'h08, 0, 0});
        vecs.push_back('{1, 0, 1, 1, 3'd3, 4'd0, 8'h00, 0, 0});

        for (int i = 0; i < vecs.size(); i++) begin
            set_in(vecs[i].rst_n, vecs[i].en, vecs[i].mode, vecs[i].start, vecs[i].a, vecs[i].dwell);
            cycle();
            chk("vec_d",    bus.D,           vecs[i].exp_d);
            chk("vec_busy", {7'd0, bus.BUSY}, {7'd0, vecs[i].exp_busy});
            chk("vec_done", {7'd0, bus.DONE}, {7'd0, vecs[i].exp_done});
        end

        // Scan from 6 with no dwell: wraps through 0, then a single DONE cycle.
        exp29 = '{8'h40, 8'h80, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20};
        start_scan(3'd6, 4'd0);
        chk("scan_d", bus.D, exp29[0]);
        for (int i = 1; i < 8; i++) begin
            cycle();
            chk("scan_d",    bus.D,           exp29[i]);
            chk("scan_busy", {7'd0, bus.BUSY}, 8'h01);
        end
        cycle();
        chk("scan_end_d",    bus.D,           8'h00);
        chk("scan_end_busy", {7'd0, bus.BUSY}, 8'h00);
        chk("scan_end_done", {7'd0, bus.DONE}, 8'h01);
        cycle();
        chk("scan_done_pulse", {7'd0, bus.DONE}, 8'h00);

        // Dwell of 2; a later DWELL change must not stretch the scan.
        start_scan(3'd0, 4'd2);
        bus.DWELL = 4'd5;
        k = 0;
        seen_done = 0;
        chk("dwell_d", bus.D, 8'h01);
        for (int i = 0; i < 60 && !seen_done; i++) begin
            cycle();
            if (bus.DONE) seen_done = 1;
            else begin
                k++;
                oh = 8'h01 << (k / 3);
                chk("dwell_d", bus.D, oh);
            end
        end
        chk("dwell_seen_done", {7'd0, seen_done}, 8'h01);
        chk("dwell_nonzero_cycles", 8'(k + 1), 8'd24);

        // EN dropped during the 5th scan cycle: no DONE afterwards.
        start_scan(3'd2, 4'd0);
        for (int i = 0; i < 4; i++) cycle();
        bus.EN = 0;
        cycle();
        chk("abort_en_d",    bus.D,           8'h00);
        chk("abort_en_busy", {7'd0, bus.BUSY}, 8'h00);
        set_in(1, 1, 1, 0, 3'd0, 4'd0);
        for (int i = 0; i < 12; i++) begin
            cycle();
            chk("abort_en_no_done", {7'd0, bus.DONE}, 8'h00);
        end

        // MODE dropped mid-scan switches straight to direct decode.
        start_scan(3'd0, 4'd1);
        for (int i = 0; i < 3; i++) cycle();
        bus.MODE = 0;
        bus.A    = 3'd3;
        cycle();
        chk("abort_mode_d",    bus.D,           8'h08);
        chk("abort_mode_busy", {7'd0, bus.BUSY}, 8'h00);
        chk("abort_mode_done", {7'd0, bus.DONE}, 8'h00);

        // START held through DONE: next scan begins right after the DONE cycle.
        set_in(1, 1, 1, 1, 3'd1, 4'd0);
        cycle();
        chk("b2b_first_d", bus.D, 8'h02);
        bus.A = 3'd5;
        for (int i = 0; i < 7; i++) begin
            cycle();
            chk("b2b_busy", {7'd0, bus.BUSY}, 8'h01);
        end
        cycle();
        chk("b2b_done", {7'd0, bus.DONE}, 8'h01);
        cycle();
        chk("b2b_new_d",    bus.D,           8'h20);
        chk("b2b_new_busy", {7'd0, bus.BUSY}, 8'h01);
        bus.START = 0;
        bus.EN    = 0;
        cycle();

        // Reset on the 3rd scan cycle, then held while direct inputs are presented.
        start_scan(3'd1, 4'd0);
        for (int i = 0; i < 2; i++) cycle();
        rst_n = 0;
        cycle();
        chk("rst_d",    bus.D,           8'h00);
        chk("rst_busy", {7'd0, bus.BUSY}, 8'h00);
        chk("rst_done", {7'd0, bus.DONE}, 8'h00);
        set_in(0, 1, 0, 0, 3'd2, 4'd0);
        cycle();
        chk("rst_hold_d", bus.D, 8'h00);
        rst_n = 1;
        cycle();
        chk("rst_release_d", bus.D, 8'h04);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst_n     = ($urandom_range(0, 99) != 0);
            bus.EN    = ($urandom_range(0, 29) != 0);
            bus.MODE  = ($urandom_range(0, 19) != 0);
            bus.START = ($urandom_range(0, 5) == 0);
            bus.A     = 3'($urandom_range(0, 7));
            bus.DWELL = 4'($urandom_range(0, 3));
            if ($urandom_range(0, 200) == 0) bus.DWELL = 4'd15;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
